register_operand: RTL and testbench

- Input-side operand register for the modular-exponentiation core; counterpart of the output result register that captures C on eoc.
- Accepts writes of message M, exponent E and modulus N over a simple strobe interface.
- Validates the operands, issues a single-cycle start pulse to the engine, and tracks busy until eoc.
- A watchdog aborts a run if eoc never arrives.

---
 rtl/register_operand_pkg.sv | 17 +
 rtl/rsa_watchdog.sv | 29 ++
 rtl/register_operand.sv | 143 ++++++++++++++
 tb/tb_register_operand.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_operand_pkg.sv
// Shared definitions for the modular-exponentiation operand/result registers and engine.
package register_operand_pkg;

   localparam int OPERAND_W = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LAUNCH = 2'b01,
      RUN    = 2'b10
   } state_t;

   localparam logic [1:0] SEL_M    = 2'b00;
   localparam logic [1:0] SEL_E    = 2'b01;
   localparam logic [1:0] SEL_N    = 2'b10;
   localparam logic [1:0] SEL_RSVD = 2'b11;

endpackage

// File: rtl/rsa_watchdog.sv
// Run-length watchdog: up-counter with clear and increment, flags the terminal count TIMEOUT-1.
module rsa_watchdog #(
   parameter int TIMEOUT = 2048,
   parameter int TO_W    = 11
) (
   input  logic clk,
   input  logic rstb,
   input  logic en,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [TO_W-1:0] count;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         count <= '0;
      end else if (en) begin
         if (clr)
            count <= '0;
         else if (inc)
            count <= count + 1'b1;
      end
   end

   assign tc = (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/register_operand.sv
// Operand register for the modexp core: captures M/E/N, validates, launches the engine, tracks busy.
//
//   state  | meaning
//   IDLE   | operands writable; start_req is checked against the valid bits and N parity
//   LAUNCH | one enabled cycle with start high; watchdog cleared on exit
//   RUN    | engine running; wait for eoc or watchdog terminal count
module register_operand
   import register_operand_pkg::*;
#(
   parameter int WIDTH   = OPERAND_W,
   parameter int TIMEOUT = 2048,
   parameter int TO_W    = 11
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             en,
   input  logic             wr,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start_req,
   input  logic             clr_err,
   input  logic             eoc,
   output logic [WIDTH-1:0] M_o,
   output logic [WIDTH-1:0] E_o,
   output logic [WIDTH-1:0] N_o,
   output logic             start,
   output logic             busy,
   output logic             ready,
   output logic             err
);

   state_t           state, state_nxt;
   logic [2:0]       vld, vld_nxt;
   logic [WIDTH-1:0] m_nxt, e_nxt, n_nxt;
   logic             start_nxt, busy_nxt, err_nxt;
   logic             err_set;
   logic             wd_clr, wd_inc, wd_tc;

   rsa_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_wd (
      .clk  (clk),
      .rstb (rstb),
      .en   (en),
      .clr  (wd_clr),
      .inc  (wd_inc),
      .tc   (wd_tc)
   );

   assign wd_clr = (state == LAUNCH);
   assign wd_inc = (state == RUN) && !eoc;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= IDLE;
         vld   <= '0;
         M_o   <= '0;
         E_o   <= '0;
         N_o   <= '0;
         start <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else if (en) begin
         state <= state_nxt;
         vld   <= vld_nxt;
         M_o   <= m_nxt;
         E_o   <= e_nxt;
         N_o   <= n_nxt;
         start <= start_nxt;
         busy  <= busy_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      vld_nxt   = vld;
      m_nxt     = M_o;
      e_nxt     = E_o;
      n_nxt     = N_o;
      start_nxt = start;
      busy_nxt  = busy;
      err_set   = 1'b0;

      case (state)
         IDLE: begin
            if (wr) begin
               // a write always takes priority; a simultaneous start_req is dropped
               case (sel)
                  SEL_M: begin m_nxt = data_in; vld_nxt[0] = 1'b1; end
                  SEL_E: begin e_nxt = data_in; vld_nxt[1] = 1'b1; end
                  SEL_N: begin n_nxt = data_in; vld_nxt[2] = 1'b1; end
                  default: err_set = 1'b1;
               endcase
            end else if (start_req) begin
               if (vld == 3'b111 && N_o[0]) begin
                  state_nxt = LAUNCH;
                  start_nxt = 1'b1;
                  busy_nxt  = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         LAUNCH: begin
            if (wr)
               err_set = 1'b1;
            start_nxt = 1'b0;
            state_nxt = RUN;
         end
         RUN: begin
            if (wr)
               err_set = 1'b1;
            if (eoc) begin
               // message is single-use; E and N stay valid for key reuse
               state_nxt  = IDLE;
               busy_nxt   = 1'b0;
               vld_nxt[0] = 1'b0;
            end else if (wd_tc) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               err_set   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            start_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase

      if (err_set)
         err_nxt = 1'b1;
      else if (clr_err)
         err_nxt = 1'b0;
      else
         err_nxt = err;
   end

   assign ready = (state == IDLE) && (vld == 3'b111);

endmodule

// File: tb/tb_register_operand.sv
// Directed bench for register_operand with a launch scoreboard and a small modexp engine model.
module tb_register_operand;

   localparam int W       = 10;
   localparam int TIMEOUT = 2048;
   localparam int TO_W    = 11;

   logic         clk = 1'b0;
   logic         rstb;
   logic         en;
   logic         wr;
   logic [1:0]   sel;
   logic [W-1:0] data_in;
   logic         start_req;
   logic         clr_err;
   logic         eoc;
   logic [W-1:0] M_o, E_o, N_o;
   logic         start, busy, ready, err;

   int total = 0;
   int bad   = 0;

   logic [W-1:0]     exp_m, exp_e, exp_n;
   logic [3*W-1:0]   sb_q[$];
   logic [3*W-1:0]   sb_item;

   register_operand #(
      .WIDTH   (W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .en        (en),
      .wr        (wr),
      .sel       (sel),
      .data_in   (data_in),
      .start_req (start_req),
      .clr_err   (clr_err),
      .eoc       (eoc),
      .M_o       (M_o),
      .E_o       (E_o),
      .N_o       (N_o),
      .start     (start),
      .busy      (busy),
      .ready     (ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic int modexp(input int b, input int e, input int n);
      int r, x, k;
      r = 1 % n;
      x = b % n;
      k = e;
      while (k > 0) begin
         if (k[0]) r = (r * x) % n;
         x = (x * x) % n;
         k = k >> 1;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_op(input logic [1:0] s, input logic [W-1:0] d);
      wr      = 1'b1;
      sel     = s;
      data_in = d;
      tick();
      wr = 1'b0;
      case (s)
         2'b00: exp_m = d;
         2'b01: exp_e = d;
         2'b10: exp_n = d;
         default: ;
      endcase
   endtask

   // Accepted launch: push expected operands, pop them when start appears, step into RUN.
   task automatic launch();
      sb_q.push_back({exp_m, exp_e, exp_n});
      start_req = 1'b1;
      tick();
      start_req = 1'b0;
      if (start === 1'b1 && sb_q.size() > 0) begin
         sb_item = sb_q.pop_front();
         chk("launch_ops", {2'b00, M_o, E_o, N_o}, {2'b00, sb_item});
      end else begin
         chk("start_seen", start, 1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      chk("busy_launch", busy, 1);
      tick();
      chk("start_one_cycle", start, 0);
   endtask

   initial begin
      rstb = 1'b0; en = 1'b1; wr = 1'b0; sel = 2'b00; data_in = '0;
      start_req = 1'b0; clr_err = 1'b0; eoc = 1'b0;
      exp_m = '0; exp_e = '0; exp_n = '0;
      #3;
      chk("rst_outs", {start, busy, ready, err}, 4'b0000);
      chk("rst_ops", {2'b00, M_o, E_o, N_o}, 32'h0);
      #4 rstb = 1'b1;
      tick();

      // nominal launch and completion
      write_op(2'b00, 10'h058);
      write_op(2'b01, 10'h007);
      write_op(2'b10, 10'h0BB);
      chk("ready_pre", ready, 1);
      launch();
      chk("engine_c", modexp(int'(M_o), int'(E_o), int'(N_o)), 32'h00B);
      tick(4);
      chk("busy_run", busy, 1);
      eoc = 1'b1;
      tick();
      eoc = 1'b0;
      chk("busy_eoc", busy, 0);
      chk("ready_post", ready, 0);
      chk("vld_post", dut.vld, 3'b110);

      // reset mid-RUN at watchdog=37
      write_op(2'b00, 10'h058);
      launch();
      tick(37);
      chk("wd_37", dut.u_wd.count, 37);
      rstb = 1'b0;
      #1;
      chk("rst_mid_outs", {start, busy, ready, err}, 4'b0000);
      chk("rst_mid_ops", {2'b00, M_o, E_o, N_o}, 32'h0);
      rstb = 1'b1;
      exp_m = '0; exp_e = '0; exp_n = '0;
      tick();
      start_req = 1'b1;
      tick();
      start_req = 1'b0;
      chk("noop_start_err", {start, busy, err}, 3'b001);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err1", err, 0);

      // even modulus rejected
      write_op(2'b00, 10'h058);
      write_op(2'b01, 10'h007);
      write_op(2'b10, 10'h0BA);
      start_req = 1'b1;
      tick();
      start_req = 1'b0;
      chk("even_n", {start, busy, err}, 3'b001);
      tick();
      chk("even_n_nostart", start, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err2", err, 0);

      // watchdog timeout at RUN cycle TIMEOUT-1
      write_op(2'b10, 10'h0BB);
      launch();
      tick(TIMEOUT - 1);
      chk("to_busy_hold", {busy, err}, 2'b10);
      tick();
      chk("to_abort", {busy, err}, 2'b01);
      chk("to_vld_kept", ready, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // eoc on the terminal cycle wins
      launch();
      tick(TIMEOUT - 1);
      eoc = 1'b1;
      tick();
      eoc = 1'b0;
      chk("eoc_vs_to", {busy, err}, 2'b00);
      chk("eoc_vs_to_rdy", ready, 0);

      // write while busy ignored and flagged
      write_op(2'b00, 10'h123);
      launch();
      wr = 1'b1; sel = 2'b00; data_in = 10'h3FF;
      tick();
      wr = 1'b0;
      chk("busy_wr_m", M_o, 10'h123);
      chk("busy_wr_err", err, 1);
      eoc = 1'b1;
      tick();
      eoc = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err3", err, 0);
      write_op(2'b11, 10'h2AA);
      chk("rsvd_err", err, 1);
      chk("rsvd_regs", {2'b00, M_o, E_o, N_o}, {2'b00, exp_m, exp_e, exp_n});
      clr_err = 1'b1;
      write_op(2'b11, 10'h155);
      clr_err = 1'b0;
      chk("clr_vs_err", err, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // clock enable freeze during RUN
      write_op(2'b00, 10'h058);
      launch();
      tick(3);
      en = 1'b0;
      tick(5);
      chk("en_wd_frozen", dut.u_wd.count, 3);
      chk("en_busy", {start, busy, err}, 3'b010);
      chk("en_ops", {2'b00, M_o, E_o, N_o}, {2'b00, exp_m, exp_e, exp_n});
      en = 1'b1;
      tick();
      chk("en_wd_resume", dut.u_wd.count, 4);
      eoc = 1'b1;
      tick();
      eoc = 1'b0;

      // simultaneous write and start_req: write wins, no launch
      wr = 1'b1; sel = 2'b00; data_in = 10'h011; start_req = 1'b1;
      tick();
      wr = 1'b0; start_req = 1'b0;
      exp_m = 10'h011;
      chk("wr_sr_m", M_o, 10'h011);
      chk("wr_sr_flags", {start, busy, err, ready}, 4'b0001);

      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
